// File: rtl/rx_serial_7e1_pkg.sv
// Shared definitions for the 7E1 serial link (receiver and transmitter).
// State codes double as the db_estado debug encoding.
package rx_tx_7e1_pkg;

    localparam int DATA_BITS = 7;
    localparam int M_DEFAULT = 434;
    localparam int N_DEFAULT = 9;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_START    = 4'd1;
    localparam logic [3:0] S_DADOS    = 4'd2;
    localparam logic [3:0] S_PARIDADE = 4'd3;
    localparam logic [3:0] S_PARADA   = 4'd4;
    localparam logic [3:0] S_ARMAZENA = 4'd5;

endpackage

// File: rtl/rx_serial_7e1_if.sv
// Serial line, consumer acknowledge and received-character bundle.
interface rx_serial_7e1_if;
    import rx_tx_7e1_pkg::*;

    logic                 entrada_serial;
    logic                 recebe;
    logic [DATA_BITS-1:0] dados_ascii;
    logic                 pronto;
    logic                 tem_dado;
    logic                 erro_paridade;
    logic                 erro_parada;
    logic                 erro_overrun;
    logic [3:0]           db_estado;

    modport master (
        output entrada_serial, recebe,
        input  dados_ascii, pronto, tem_dado,
        input  erro_paridade, erro_parada, erro_overrun, db_estado
    );

    modport slave (
        input  entrada_serial, recebe,
        output dados_ascii, pronto, tem_dado,
        output erro_paridade, erro_parada, erro_overrun, db_estado
    );

endinterface

// File: rtl/rx_serial_7e1_contador_m.sv
// Bit-timing counter: wraps at M-1; meio flags half a bit, fim a full bit.
module contador_m #(
    parameter int M = 434,
    parameter int N = 9
) (
    input  logic clock,
    input  logic reset,
    input  logic zera_s,
    input  logic conta,
    output logic fim,
    output logic meio
);

    localparam logic [N-1:0] ULTIMO = N'(M - 1);
    localparam logic [N-1:0] METADE = N'(M / 2 - 1);

    logic [N-1:0] q;

    always_ff @(posedge clock) begin
        if (reset || zera_s) begin
            q <= '0;
        end else if (conta) begin
            q <= (q == ULTIMO) ? '0 : q + N'(1);
        end
    end

    assign fim  = (q == ULTIMO);
    assign meio = (q == METADE);

endmodule

// File: rtl/rx_serial_7e1.sv
// 7E1 UART receiver: start, 7 data bits LSB first, even parity, one stop.
module rx_serial_7e1
    import rx_tx_7e1_pkg::*;
#(
    parameter int M = M_DEFAULT,
    parameter int N = N_DEFAULT
) (
    input  logic           clock,
    input  logic           reset,
    rx_serial_7e1_if.slave bus
);

    logic [1:0]           sync;
    logic                 linha;
    logic                 linha_ant;
    logic [3:0]           estado;
    logic [2:0]           idx;
    logic [DATA_BITS-1:0] dados;
    logic                 erro_p;
    logic                 zera;
    logic                 conta;
    logic                 fim;
    logic                 meio;
    logic                 armazena;

    logic [DATA_BITS-1:0] dados_r;
    logic                 tem_r;
    logic                 ep_r;
    logic                 es_r;
    logic                 ov_r;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync      <= 2'b11;
            linha_ant <= 1'b1;
        end else begin
            sync      <= {sync[0], bus.entrada_serial};
            linha_ant <= sync[1];
        end
    end

    assign linha = sync[1];

    contador_m #(.M(M), .N(N)) u_contador (
        .clock  (clock),
        .reset  (reset),
        .zera_s (zera),
        .conta  (conta),
        .fim    (fim),
        .meio   (meio)
    );

    always_comb begin
        zera  = 1'b0;
        conta = 1'b0;
        unique case (estado)
            S_START: begin
                conta = 1'b1;
                zera  = meio;
            end
            S_DADOS, S_PARIDADE, S_PARADA: conta = 1'b1;
            default: zera = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= S_IDLE;
            idx    <= '0;
            dados  <= '0;
            erro_p <= 1'b0;
        end else begin
            unique case (estado)
                S_IDLE: begin
                    // Edge, not level: a held break must not re-trigger.
                    if (linha_ant && !linha) estado <= S_START;
                end
                S_START: begin
                    if (meio) begin
                        estado <= linha ? S_IDLE : S_DADOS;
                        idx    <= '0;
                    end
                end
                S_DADOS: begin
                    if (fim) begin
                        dados[idx] <= linha;
                        if (idx == 3'(DATA_BITS - 1)) estado <= S_PARIDADE;
                        else idx <= idx + 3'd1;
                    end
                end
                S_PARIDADE: begin
                    if (fim) begin
                        erro_p <= (^dados) ^ linha;
                        estado <= S_PARADA;
                    end
                end
                S_PARADA: begin
                    if (fim) estado <= S_ARMAZENA;
                end
                default: estado <= S_IDLE;
            endcase
        end
    end

    // Results load as ARMAZENA is entered so they are valid alongside pronto.
    assign armazena = (estado == S_PARADA) && fim;

    always_ff @(posedge clock) begin
        if (reset) begin
            dados_r <= '0;
            tem_r   <= 1'b0;
            ep_r    <= 1'b0;
            es_r    <= 1'b0;
            ov_r    <= 1'b0;
        end else if (armazena) begin
            dados_r <= dados;
            ep_r    <= erro_p;
            es_r    <= ~linha;
            tem_r   <= 1'b1;
            ov_r    <= (ov_r | tem_r) & ~bus.recebe;
        end else if (bus.recebe) begin
            tem_r <= 1'b0;
            ov_r  <= 1'b0;
        end
    end

    assign bus.dados_ascii   = dados_r;
    assign bus.tem_dado      = tem_r;
    assign bus.erro_paridade = ep_r;
    assign bus.erro_parada   = es_r;
    assign bus.erro_overrun  = ov_r;
    assign bus.pronto        = (estado == S_ARMAZENA);
    assign bus.db_estado     = estado;

endmodule

// File: tb/tb_rx_serial_7e1.sv
// Testbench for rx_serial_7e1: frames checked against a character-level model.
module tb_rx_serial_7e1;

    localparam int M = 8;
    localparam int N = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    rx_serial_7e1_if bus();

    rx_serial_7e1 #(.M(M), .N(N)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int       pronto_cnt = 0;
    int       wide_cnt   = 0;
    logic     pronto_q   = 1'b0;
    logic [6:0] cap_data = '0;
    logic     cap_ep = 1'b0, cap_es = 1'b0, cap_ov = 1'b0, cap_tem = 1'b0;

    logic [6:0] m_data = '0;
    logic     m_ep = 1'b0, m_es = 1'b0, m_ov = 1'b0, m_tem = 1'b0;

    always @(negedge clock) begin
        if (bus.pronto === 1'b1) begin
            pronto_cnt = pronto_cnt + 1;
            if (pronto_q === 1'b1) wide_cnt = wide_cnt + 1;
            cap_data = bus.dados_ascii;
            cap_ep   = bus.erro_paridade;
            cap_es   = bus.erro_parada;
            cap_ov   = bus.erro_overrun;
            cap_tem  = bus.tem_dado;
        end
        pronto_q = bus.pronto;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic model_store(input logic [6:0] d, input logic par,
                               input logic stop);
        m_data = d;
        m_ep   = (^d) ^ par;
        m_es   = ~stop;
        m_ov   = m_ov | m_tem;
        m_tem  = 1'b1;
    endtask

    task automatic pulse_recebe();
        bus.recebe = 1'b1;
        tick(1);
        bus.recebe = 1'b0;
        m_tem = 1'b0;
        m_ov  = 1'b0;
    endtask

    task automatic drive_bits(input logic [6:0] d, input logic par,
                              input logic stop, input int nbits);
        logic [9:0] f;
        f = {stop, par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            bus.entrada_serial = f[i];
            tick(M);
        end
    endtask

    task automatic send(input logic [6:0] d, input logic par,
                        input logic stop, output logic got);
        int base;
        base = pronto_cnt;
        drive_bits(d, par, stop, 10);
        for (int i = 0; i < 3 * M && pronto_cnt == base; i++) tick(1);
        got = (pronto_cnt == base + 1);
    endtask

    task automatic test_reset();
        bus.entrada_serial = 1'b1;
        bus.recebe = 1'b0;
        reset = 1'b1;
        tick(3);
        n_cmp++;
        if ({bus.dados_ascii, bus.pronto, bus.tem_dado, bus.erro_paridade,
             bus.erro_parada, bus.erro_overrun, bus.db_estado} !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_outputs got %h %b%b%b%b%b st %0d want all 0",
                     bus.dados_ascii, bus.pronto, bus.tem_dado,
                     bus.erro_paridade, bus.erro_parada, bus.erro_overrun,
                     bus.db_estado);
        end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_frame_a();
        logic got;
        send(7'h41, 1'b0, 1'b1, got);
        model_store(7'h41, 1'b0, 1'b1);
        n_cmp++;
        if (got !== 1'b1) begin
            n_bad++;
            $display("FAIL a_pronto got %b want 1", got);
        end
        n_cmp++;
        if ({cap_data, cap_ep, cap_es, cap_ov, cap_tem} !==
            {m_data, m_ep, m_es, m_ov, m_tem}) begin
            n_bad++;
            $display("FAIL a_frame got %h %b%b%b%b want %h %b%b%b%b",
                     cap_data, cap_ep, cap_es, cap_ov, cap_tem,
                     m_data, m_ep, m_es, m_ov, m_tem);
        end
        n_cmp++;
        if (wide_cnt !== 0 || bus.pronto !== 1'b0) begin
            n_bad++;
            $display("FAIL a_pulse got wide %0d pronto %b want 0 0",
                     wide_cnt, bus.pronto);
        end
        pulse_recebe();
        n_cmp++;
        if (bus.tem_dado !== 1'b0) begin
            n_bad++;
            $display("FAIL a_ack got tem %b want 0", bus.tem_dado);
        end
    endtask

    task automatic test_parity();
        logic got;
        for (int k = 0; k < 2; k++) begin
            logic par;
            par = (k == 0) ? 1'b1 : 1'b0;
            send(7'h43, par, 1'b1, got);
            model_store(7'h43, par, 1'b1);
            n_cmp++;
            if (got !== 1'b1 ||
                {cap_data, cap_ep, cap_es, cap_ov} !== {m_data, m_ep, m_es, m_ov}) begin
                n_bad++;
                $display("FAIL parity%0d got %b %h %b%b%b want 1 %h %b%b%b", k,
                         got, cap_data, cap_ep, cap_es, cap_ov,
                         m_data, m_ep, m_es, m_ov);
            end
            pulse_recebe();
        end
    endtask

    task automatic test_glitch();
        int base;
        base = pronto_cnt;
        bus.entrada_serial = 1'b0;
        tick(3);
        bus.entrada_serial = 1'b1;
        tick(2 * M);
        n_cmp++;
        if (pronto_cnt !== base || bus.db_estado !== 4'd0) begin
            n_bad++;
            $display("FAIL glitch got pronto %0d st %0d want %0d 0",
                     pronto_cnt - base, bus.db_estado, 0);
        end
        n_cmp++;
        if ({bus.dados_ascii, bus.erro_paridade, bus.erro_parada,
             bus.erro_overrun, bus.tem_dado} !== {m_data, m_ep, m_es, m_ov, m_tem}) begin
            n_bad++;
            $display("FAIL glitch_hold got %h want %h", bus.dados_ascii, m_data);
        end
    endtask

    task automatic test_stop_error();
        logic got;
        int base;
        send(7'h33, 1'b0, 1'b0, got);
        model_store(7'h33, 1'b0, 1'b0);
        n_cmp++;
        if (got !== 1'b1 ||
            {cap_data, cap_ep, cap_es} !== {m_data, m_ep, m_es}) begin
            n_bad++;
            $display("FAIL stop got %b %h %b%b want 1 %h %b%b",
                     got, cap_data, cap_ep, cap_es, m_data, m_ep, m_es);
        end
        base = pronto_cnt;
        tick(4 * M);
        n_cmp++;
        if (pronto_cnt !== base || bus.db_estado !== 4'd0) begin
            n_bad++;
            $display("FAIL break got pronto %0d st %0d want 0 0",
                     pronto_cnt - base, bus.db_estado);
        end
        pulse_recebe();
        bus.entrada_serial = 1'b1;
        tick(M);
        send(7'h41, 1'b0, 1'b1, got);
        model_store(7'h41, 1'b0, 1'b1);
        n_cmp++;
        if (got !== 1'b1 || {cap_data, cap_es} !== {m_data, m_es}) begin
            n_bad++;
            $display("FAIL after_break got %b %h %b want 1 %h %b",
                     got, cap_data, cap_es, m_data, m_es);
        end
    endtask

    task automatic test_overrun();
        logic got;
        pulse_recebe();
        send(7'h41, 1'b0, 1'b1, got);
        model_store(7'h41, 1'b0, 1'b1);
        send(7'h42, 1'b0, 1'b1, got);
        model_store(7'h42, 1'b0, 1'b1);
        n_cmp++;
        if ({bus.dados_ascii, bus.erro_overrun, bus.tem_dado} !==
            {m_data, m_ov, m_tem}) begin
            n_bad++;
            $display("FAIL overrun got %h %b %b want %h %b %b",
                     bus.dados_ascii, bus.erro_overrun, bus.tem_dado,
                     m_data, m_ov, m_tem);
        end
        pulse_recebe();
        n_cmp++;
        if ({bus.erro_overrun, bus.tem_dado} !== {m_ov, m_tem}) begin
            n_bad++;
            $display("FAIL overrun_ack got %b %b want %b %b",
                     bus.erro_overrun, bus.tem_dado, m_ov, m_tem);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        base = pronto_cnt;
        drive_bits(7'h15, 1'b1, 1'b1, 10);
        model_store(7'h15, 1'b1, 1'b1);
        drive_bits(7'h6a, 1'b0, 1'b1, 10);
        model_store(7'h6a, 1'b0, 1'b1);
        for (int i = 0; i < 3 * M && pronto_cnt < base + 2; i++) tick(1);
        n_cmp++;
        if (pronto_cnt !== base + 2 ||
            {cap_data, cap_ep, cap_es, cap_ov} !== {m_data, m_ep, m_es, m_ov}) begin
            n_bad++;
            $display("FAIL b2b got n %0d %h %b%b%b want 2 %h %b%b%b",
                     pronto_cnt - base, cap_data, cap_ep, cap_es, cap_ov,
                     m_data, m_ep, m_es, m_ov);
        end
        pulse_recebe();
    endtask

    task automatic test_reset_mid();
        logic got;
        int base;
        base = pronto_cnt;
        drive_bits(7'h41, 1'b0, 1'b1, 4);
        tick(M / 2);
        n_cmp++;
        if (bus.db_estado !== 4'd2) begin
            n_bad++;
            $display("FAIL mid_state got %0d want 2", bus.db_estado);
        end
        reset = 1'b1;
        tick(1);
        m_data = '0; m_ep = 1'b0; m_es = 1'b0; m_ov = 1'b0; m_tem = 1'b0;
        n_cmp++;
        if ({bus.dados_ascii, bus.pronto, bus.tem_dado, bus.erro_paridade,
             bus.erro_parada, bus.erro_overrun, bus.db_estado} !== 16'h0) begin
            n_bad++;
            $display("FAIL mid_reset got %h st %0d want 0 0",
                     bus.dados_ascii, bus.db_estado);
        end
        bus.entrada_serial = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2 * M);
        send(7'h41, 1'b0, 1'b1, got);
        model_store(7'h41, 1'b0, 1'b1);
        n_cmp++;
        if (pronto_cnt !== base + 1 || got !== 1'b1 ||
            {cap_data, cap_ep, cap_es, cap_ov} !== {m_data, m_ep, m_es, m_ov}) begin
            n_bad++;
            $display("FAIL mid_next got n %0d %h %b%b%b want 1 %h %b%b%b",
                     pronto_cnt - base, cap_data, cap_ep, cap_es, cap_ov,
                     m_data, m_ep, m_es, m_ov);
        end
        pulse_recebe();
    endtask

    task automatic test_random();
        logic got;
        for (int k = 0; k < 10; k++) begin
            logic [6:0] d;
            logic par, stop;
            d    = 7'($urandom);
            par  = (^d) ^ ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 4) != 0);
            send(d, par, stop, got);
            model_store(d, par, stop);
            n_cmp++;
            if (got !== 1'b1 ||
                {cap_data, cap_ep, cap_es, cap_ov, cap_tem} !==
                {m_data, m_ep, m_es, m_ov, m_tem}) begin
                n_bad++;
                $display("FAIL rand%0d got %b %h %b%b%b%b want 1 %h %b%b%b%b",
                         k, got, cap_data, cap_ep, cap_es, cap_ov, cap_tem,
                         m_data, m_ep, m_es, m_ov, m_tem);
            end
            if (!stop) begin
                bus.entrada_serial = 1'b1;
                tick(M);
            end
            if ($urandom_range(0, 1) == 1) pulse_recebe();
        end
        n_cmp++;
        if (wide_cnt !== 0) begin
            n_bad++;
            $display("FAIL pronto_width got %0d wide want 0", wide_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_frame_a();
        test_parity();
        test_glitch();
        test_stop_error();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
